// File: rtl/input_map_pkg.sv
// Shared definitions for the memory-mapped input responder: register offsets,
// access-size encoding and the byte-lane mask used by the write path.
package input_map_pkg;

    localparam logic [31:0] OFF_SW_STATE   = 32'h0000_0000;
    localparam logic [31:0] OFF_BTN_STATE  = 32'h0000_0004;
    localparam logic [31:0] OFF_BTN_EVENT  = 32'h0000_0008;
    localparam logic [31:0] OFF_EVENT_MASK = 32'h0000_000C;
    localparam logic [31:0] OFF_SW_CHANGE  = 32'h0000_0010;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10
    } mem_size_t;

    // Lanes shifted past byte 3 fall off the 4-bit result, which drops them.
    function automatic logic [3:0] lane_mask(input logic [1:0] size,
                                             input logic [1:0] addr_lo);
        logic [3:0] base;
        if (size == SIZE_BYTE)
            base = 4'b0001;
        else if (size == SIZE_HALF)
            base = 4'b0011;
        else
            base = 4'b1111;
        return base << addr_lo;
    endfunction

endpackage

// File: rtl/input_map_debouncer.sv
// Two-flop synchronizer followed by a stability counter; rise/fall pulse on
// the same edge that updates the debounced output.
module debouncer #(
    parameter int DEBOUNCE_CYCLES = 2000000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic stable,
    output logic rise,
    output logic fall
);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;
    logic             w_diff;
    logic             w_update;

    assign w_diff   = (r_sync2 != r_stable);
    assign w_update = w_diff && (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
            if (!w_diff) begin
                r_cnt <= '0;
            end else if (w_update) begin
                r_cnt    <= '0;
                r_stable <= r_sync2;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign stable = r_stable;
    assign rise   = w_update & r_sync2;
    assign fall   = w_update & ~r_sync2;

endmodule

// File: rtl/input_map.sv
// Memory-mapped switch/button responder: debounced state, sticky W1C events,
// a maskable registered interrupt, and size/offset-aware read/write access.
module input_map
    import input_map_pkg::*;
#(
    parameter int NUM_SW          = 16,
    parameter int NUM_BTN         = 5,
    parameter int DEBOUNCE_CYCLES = 2000000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_SW-1:0]   sw,
    input  logic [NUM_BTN-1:0]  btn,
    input  logic [31:0]         input_address,
    input  logic [31:0]         input_in,
    input  logic [1:0]          input_size,
    input  logic                input_write_enable,
    output logic [31:0]         input_out,
    output logic                irq
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    // Only button bits and the switch-change gate exist in EVENT_MASK.
    localparam logic [31:0] MASK_IMPL = 32'h8000_0000 | 32'((64'd1 << NUM_BTN) - 64'd1);

    logic [NUM_SW-1:0]  w_sw_stable;
    logic [NUM_SW-1:0]  w_sw_rise;
    logic [NUM_SW-1:0]  w_sw_fall;
    logic [NUM_BTN-1:0] w_btn_stable;
    logic [NUM_BTN-1:0] w_btn_rise;
    logic [NUM_BTN-1:0] w_btn_fall;
    logic               w_unused_btn_fall;

    logic [NUM_BTN-1:0] r_btn_event;
    logic [NUM_SW-1:0]  r_sw_change;
    logic [31:0]        r_event_mask;
    logic               r_irq;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SW; gi++) begin : g_sw
            debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db (
                .clk(clk), .rst_n(rst_n), .raw(sw[gi]),
                .stable(w_sw_stable[gi]), .rise(w_sw_rise[gi]), .fall(w_sw_fall[gi])
            );
        end
        for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
            debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db (
                .clk(clk), .rst_n(rst_n), .raw(btn[gi]),
                .stable(w_btn_stable[gi]), .rise(w_btn_rise[gi]), .fall(w_btn_fall[gi])
            );
        end
    endgenerate

    // Button releases are not events; only presses are captured.
    assign w_unused_btn_fall = ^w_btn_fall;

    logic [29:0] w_word_idx;
    logic [3:0]  w_lanes;
    logic [31:0] w_bitmask;
    logic [31:0] w_wbits;
    logic        w_sel_bev;
    logic        w_sel_mask;
    logic        w_sel_swc;

    assign w_word_idx = input_address[31:2];
    assign w_lanes    = lane_mask(input_size, input_address[1:0]);
    assign w_bitmask  = {{8{w_lanes[3]}}, {8{w_lanes[2]}}, {8{w_lanes[1]}}, {8{w_lanes[0]}}};
    assign w_wbits    = (input_in << {input_address[1:0], 3'b000}) & w_bitmask;
    assign w_sel_bev  = input_write_enable && (w_word_idx == OFF_BTN_EVENT[31:2]);
    assign w_sel_mask = input_write_enable && (w_word_idx == OFF_EVENT_MASK[31:2]);
    assign w_sel_swc  = input_write_enable && (w_word_idx == OFF_SW_CHANGE[31:2]);

    logic [NUM_BTN-1:0] w_btn_clr;
    logic [NUM_SW-1:0]  w_sw_clr;

    assign w_btn_clr = w_sel_bev ? w_wbits[NUM_BTN-1:0] : '0;
    assign w_sw_clr  = w_sel_swc ? w_wbits[NUM_SW-1:0]  : '0;

    // Setting after clearing makes a same-cycle set win over W1C.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_btn_event  <= '0;
            r_sw_change  <= '0;
            r_event_mask <= '0;
            r_irq        <= 1'b0;
        end else begin
            r_btn_event <= (r_btn_event & ~w_btn_clr) | w_btn_rise;
            r_sw_change <= (r_sw_change & ~w_sw_clr) | w_sw_rise | w_sw_fall;
            if (w_sel_mask)
                r_event_mask <= (r_event_mask & ~w_bitmask) | (w_wbits & MASK_IMPL);
            r_irq <= (|(r_btn_event & r_event_mask[NUM_BTN-1:0]))
                   | ((|r_sw_change) & r_event_mask[31]);
        end
    end

    logic [31:0] w_reg;
    logic [31:0] w_shifted;

    always_comb begin
        w_reg = '0;
        case (w_word_idx)
            OFF_SW_STATE[31:2]:   w_reg[NUM_SW-1:0]  = w_sw_stable;
            OFF_BTN_STATE[31:2]:  w_reg[NUM_BTN-1:0] = w_btn_stable;
            OFF_BTN_EVENT[31:2]:  w_reg[NUM_BTN-1:0] = r_btn_event;
            OFF_EVENT_MASK[31:2]: w_reg              = r_event_mask;
            OFF_SW_CHANGE[31:2]:  w_reg[NUM_SW-1:0]  = r_sw_change;
            default:              w_reg              = '0;
        endcase
    end

    assign w_shifted = w_reg >> {input_address[1:0], 3'b000};

    always_comb begin
        input_out = w_shifted;
        if (input_size == SIZE_BYTE)
            input_out = {24'd0, w_shifted[7:0]};
        else if (input_size == SIZE_HALF)
            input_out = {16'd0, w_shifted[15:0]};
    end

    assign irq = r_irq;

endmodule
